// File: rtl/tlp_fragmentation_engine.sv
// TX-path TLP fragmentation engine: pops whole TLPs from a FWFT TLP FIFO
// (one or two entries per cycle) and re-beats them onto a 2*FIFO_W DLL bus
// with sop/eop, per-beat valid DW count and total TLP length.
module tlp_fragmentation_engine #(
  parameter int unsigned FIFO_DW    = 4,
  parameter int unsigned FIFO_ADD_W = 9,
  parameter int unsigned STORE_FWD  = 0,
  parameter int unsigned LEN_W      = 11
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [FIFO_ADD_W:0]           Count,
  input  logic [32*FIFO_DW-1:0]         rd_data_1,
  input  logic [32*FIFO_DW-1:0]         rd_data_2,
  output logic                          rd_en,
  output logic                          rd_mode,
  input  logic                          Halt,
  input  logic                          Throttle,
  output logic [64*FIFO_DW-1:0]         TLP,
  output logic                          TLP_valid,
  output logic                          sop,
  output logic                          eop,
  output logic [$clog2(2*FIFO_DW):0]    Valid_DW,
  output logic [LEN_W-1:0]              Length
);

  localparam int unsigned FIFO_W  = 32 * FIFO_DW;
  localparam int unsigned BEAT_DW = 2 * FIFO_DW;
  localparam int unsigned BEAT_W  = 2 * FIFO_W;
  localparam int unsigned VDW_W   = $clog2(BEAT_DW) + 1;
  localparam int unsigned CNT_W   = FIFO_ADD_W + 1;
  localparam int unsigned CMP_W   = (CNT_W > LEN_W) ? CNT_W : LEN_W;

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_ACTIVE = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [LEN_W-1:0]   rem_ent_q, rem_ent_d;
  logic [LEN_W-1:0]   rem_dw_q, rem_dw_d;
  logic [BEAT_W-1:0]  tlp_q, tlp_d;
  logic               tlp_valid_q, tlp_valid_d;
  logic               sop_q, sop_d;
  logic               eop_q, eop_d;
  logic [VDW_W-1:0]   valid_dw_q, valid_dw_d;
  logic [LEN_W-1:0]   length_q, length_d;

  logic [2:0]         hdr_fmt;
  logic               hdr_td;
  logic [9:0]         hdr_len;
  logic [LEN_W-1:0]   hdr_pay_dw;
  logic [LEN_W-1:0]   hdr_tot_dw;
  logic [LEN_W-1:0]   hdr_tot_ent;

  logic               halt_block;
  logic [CMP_W-1:0]   count_x;
  logic [LEN_W-1:0]   ent_left;
  logic [LEN_W-1:0]   dw_left;
  logic [LEN_W-1:0]   n_ent;
  logic [LEN_W-1:0]   need_ent;
  logic [LEN_W-1:0]   beat_dw;
  logic               pop;
  logic               last_pop;
  logic [BEAT_W-1:0]  raw_beat;
  logic [BEAT_W-1:0]  beat_data;

  // Header decode of DW0 at the FIFO head: total DWs and total FIFO entries
  always_comb begin
    hdr_fmt    = rd_data_1[31:29];
    hdr_td     = rd_data_1[15];
    hdr_len    = rd_data_1[9:0];
    hdr_pay_dw = '0;
    if (hdr_fmt[1]) begin
      hdr_pay_dw = (hdr_len == 10'd0) ? LEN_W'(1024) : LEN_W'(hdr_len);
    end
    hdr_tot_dw  = LEN_W'(hdr_fmt[0] ? 4 : 3) + hdr_pay_dw + LEN_W'(hdr_td);
    hdr_tot_ent = (hdr_tot_dw + LEN_W'(FIFO_DW - 1)) / LEN_W'(FIFO_DW);
  end

  // Pop decision: IDLE uses the fresh header, ACTIVE the remaining counters
  always_comb begin
    halt_block = Halt & tlp_valid_q;
    count_x    = CMP_W'(Count);
    if (state_q == S_IDLE) begin
      ent_left = hdr_tot_ent;
      dw_left  = hdr_tot_dw;
    end else begin
      ent_left = rem_ent_q;
      dw_left  = rem_dw_q;
    end
    n_ent    = (ent_left >= LEN_W'(2)) ? LEN_W'(2) : ent_left;
    beat_dw  = (dw_left >= LEN_W'(BEAT_DW)) ? LEN_W'(BEAT_DW) : dw_left;
    last_pop = (ent_left == n_ent);
    need_ent = (STORE_FWD != 0) ? ent_left : n_ent;
    if (state_q == S_IDLE) begin
      pop = (Count != '0) && !Throttle && (count_x >= CMP_W'(need_ent));
    end else begin
      pop = (count_x >= CMP_W'(n_ent));
    end
    pop = pop && !halt_block && !rst;
  end

  assign rd_en   = pop;
  assign rd_mode = pop && (n_ent == LEN_W'(2));

  // Beat assembly: head entry in the low half, zero every lane past the TLP end
  always_comb begin
    raw_beat  = {rd_data_2, rd_data_1};
    beat_data = '0;
    for (int unsigned i = 0; i < BEAT_DW; i++) begin
      if (LEN_W'(i) < beat_dw) begin
        beat_data[32*i +: 32] = raw_beat[32*i +: 32];
      end
    end
  end

  // Next-state and registered-output logic; a held beat freezes everything
  always_comb begin
    state_d     = state_q;
    rem_ent_d   = rem_ent_q;
    rem_dw_d    = rem_dw_q;
    tlp_d       = tlp_q;
    tlp_valid_d = tlp_valid_q;
    sop_d       = sop_q;
    eop_d       = eop_q;
    valid_dw_d  = valid_dw_q;
    length_d    = length_q;
    if (!halt_block) begin
      tlp_d       = '0;
      tlp_valid_d = 1'b0;
      sop_d       = 1'b0;
      eop_d       = 1'b0;
      valid_dw_d  = '0;
      if (pop) begin
        tlp_d       = beat_data;
        tlp_valid_d = 1'b1;
        valid_dw_d  = VDW_W'(beat_dw);
        eop_d       = last_pop;
        rem_ent_d   = ent_left - n_ent;
        rem_dw_d    = dw_left - beat_dw;
        if (state_q == S_IDLE) begin
          sop_d    = 1'b1;
          length_d = hdr_tot_dw;
        end
        state_d = last_pop ? S_IDLE : S_ACTIVE;
      end
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rem_ent_q   <= '0;
      rem_dw_q    <= '0;
      tlp_q       <= '0;
      tlp_valid_q <= 1'b0;
      sop_q       <= 1'b0;
      eop_q       <= 1'b0;
      valid_dw_q  <= '0;
      length_q    <= '0;
    end else begin
      state_q     <= state_d;
      rem_ent_q   <= rem_ent_d;
      rem_dw_q    <= rem_dw_d;
      tlp_q       <= tlp_d;
      tlp_valid_q <= tlp_valid_d;
      sop_q       <= sop_d;
      eop_q       <= eop_d;
      valid_dw_q  <= valid_dw_d;
      length_q    <= length_d;
    end
  end

  assign TLP       = tlp_q;
  assign TLP_valid = tlp_valid_q;
  assign sop       = sop_q;
  assign eop       = eop_q;
  assign Valid_DW  = valid_dw_q;
  assign Length    = length_q;

endmodule

// File: tb/tb_tlp_fragmentation_engine.sv
// Bench for tlp_fragmentation_engine: FIFO model plus a beat scoreboard filled
// when TLPs are pushed, a vector table, and hand sequences for flow control.
module tb_tlp_fragmentation_engine;

  typedef struct packed {
    logic [255:0] data;
    logic         sop;
    logic         eop;
    logic [3:0]   vdw;
    logic [10:0]  len;
  } beat_t;

  typedef struct {
    logic [2:0] fmt;
    logic       td;
    logic [9:0] len;
    int         tot_dw;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [9:0]   count;
  logic [127:0] rd1, rd2;
  logic         rd_en, rd_mode, halt, throttle;
  logic [255:0] tlp;
  logic         tlp_valid, sop, eop;
  logic [3:0]   vdw;
  logic [10:0]  length;

  logic [9:0]   sf_count;
  logic [127:0] sf_rd1, sf_rd2;
  logic         sf_rd_en, sf_rd_mode;
  logic [255:0] sf_tlp;
  logic         sf_valid, sf_sop, sf_eop;
  logic [3:0]   sf_vdw;
  logic [10:0]  sf_length;

  logic [127:0] fifo_q [$];
  beat_t        exp_q [$];
  int           arrived;
  int           errors, checks;
  int           beats_seen;
  logic [3:0]   last_vdw;
  logic         last_rd_en, last_rd_mode, last_valid;
  logic         prev_hb;
  logic [273:0] snap;

  always #5 clk = ~clk;

  tlp_fragmentation_engine #(.FIFO_DW(4), .FIFO_ADD_W(9), .STORE_FWD(0), .LEN_W(11)) u_dut (
    .clk(clk), .rst(rst), .Count(count), .rd_data_1(rd1), .rd_data_2(rd2),
    .rd_en(rd_en), .rd_mode(rd_mode), .Halt(halt), .Throttle(throttle),
    .TLP(tlp), .TLP_valid(tlp_valid), .sop(sop), .eop(eop),
    .Valid_DW(vdw), .Length(length)
  );

  tlp_fragmentation_engine #(.FIFO_DW(4), .FIFO_ADD_W(9), .STORE_FWD(1), .LEN_W(11)) u_sf (
    .clk(clk), .rst(rst), .Count(sf_count), .rd_data_1(sf_rd1), .rd_data_2(sf_rd2),
    .rd_en(sf_rd_en), .rd_mode(sf_rd_mode), .Halt(1'b0), .Throttle(1'b0),
    .TLP(sf_tlp), .TLP_valid(sf_valid), .sop(sf_sop), .eop(sf_eop),
    .Valid_DW(sf_vdw), .Length(sf_length)
  );

  task automatic chk(input string name, input logic [299:0] act, input logic [299:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void drive_fifo();
    int vis;
    vis = (fifo_q.size() < arrived) ? fifo_q.size() : arrived;
    if (vis > 1023) vis = 1023;
    count = 10'(vis);
    rd1 = (fifo_q.size() > 0) ? fifo_q[0] : '0;
    rd2 = (fifo_q.size() > 1) ? fifo_q[1] : '0;
  endfunction

  // Push a TLP into the FIFO model and its expected DLL beats into the scoreboard
  task automatic push_tlp(input logic [2:0] fmt, input logic td, input logic [9:0] len,
                          input int tot, input logic [7:0] tag);
    logic [31:0]  dw [$];
    logic [127:0] ent;
    beat_t        b;
    int           nb;
    dw.push_back({fmt, 13'h1B3C, td, 5'h15, len});
    for (int k = 1; k < tot; k++) dw.push_back({tag, 8'hC0, 16'(k)});
    for (int e = 0; e * 4 < tot; e++) begin
      for (int i = 0; i < 4; i++)
        ent[32*i +: 32] = (e * 4 + i < tot) ? dw[e*4+i] : {16'hDEAD, 8'(e), 8'(i)};
      fifo_q.push_back(ent);
    end
    nb = (tot + 7) / 8;
    for (int k = 0; k < nb; k++) begin
      b.data = '0;
      for (int i = 0; i < 8; i++)
        if (8 * k + i < tot) b.data[32*i +: 32] = dw[8*k+i];
      b.sop = (k == 0);
      b.eop = (k == nb - 1);
      b.vdw = 4'((tot - 8 * k > 8) ? 8 : tot - 8 * k);
      b.len = 11'(tot);
      exp_q.push_back(b);
    end
    drive_fifo();
  endtask

  // One clock: sample/check on negedge, then apply the FIFO pop after posedge
  task automatic step();
    beat_t got, exp;
    logic  hb;
    int    n;
    @(negedge clk);
    last_rd_en   = rd_en;
    last_rd_mode = rd_mode;
    last_valid   = tlp_valid;
    got = {tlp, sop, eop, vdw, length};
    hb  = tlp_valid && halt;
    if (prev_hb) chk("halt_hold", 300'({tlp_valid, got}), 300'(snap));
    if (hb) chk("halt_rd_en", 300'(rd_en), 300'(0));
    if (tlp_valid && !halt) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: got sop=%0b eop=%0b vdw=%0d len=%0d, expected no beat",
                 sop, eop, vdw, length);
      end else begin
        exp = exp_q.pop_front();
        chk("beat", 300'(got), 300'(exp));
        beats_seen++;
        last_vdw = vdw;
      end
    end
    prev_hb = hb;
    snap    = {tlp_valid, got};
    @(posedge clk);
    #1;
    if (last_rd_en) begin
      n = last_rd_mode ? 2 : 1;
      for (int i = 0; i < n; i++) if (fifo_q.size() > 0) fifo_q.delete(0);
      arrived -= n;
    end
    drive_fifo();
  endtask

  task automatic drain(input int budget, input string name);
    int c;
    c = 0;
    while (exp_q.size() > 0 && c < budget) begin
      step();
      c++;
    end
    chk({"drain_", name}, 300'(exp_q.size()), 300'(0));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    vec_t tbl [9];
    int   seen, bubbles, c;
    tbl[0] = '{3'b000, 1'b0, 10'd1,  3};
    tbl[1] = '{3'b001, 1'b0, 10'd1,  4};
    tbl[2] = '{3'b010, 1'b0, 10'd1,  4};
    tbl[3] = '{3'b011, 1'b0, 10'd8,  12};
    tbl[4] = '{3'b010, 1'b1, 10'd5,  9};
    tbl[5] = '{3'b011, 1'b1, 10'd16, 21};
    tbl[6] = '{3'b000, 1'b1, 10'd0,  4};
    tbl[7] = '{3'b011, 1'b0, 10'd5,  9};
    tbl[8] = '{3'b010, 1'b0, 10'd14, 17};

    errors = 0; checks = 0; beats_seen = 0; last_vdw = '0;
    halt = 1'b0; throttle = 1'b0; rst = 1'b1; arrived = 1 << 20;
    prev_hb = 1'b0; snap = '0;
    last_rd_en = 1'b0; last_rd_mode = 1'b0; last_valid = 1'b0;
    sf_count = '0; sf_rd1 = '0; sf_rd2 = '0;
    drive_fifo();

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", 300'({tlp_valid, sop, eop, vdw, length, tlp}), 300'(0));
    chk("reset_sf_outputs", 300'({sf_valid, sf_sop, sf_eop, sf_vdw, sf_length, sf_tlp}), 300'(0));
    rst = 1'b0;
    step();
    chk("idle_empty_rd_en", 300'(last_rd_en), 300'(0));

    // case 1: 3DW MRd, single entry
    push_tlp(3'b000, 1'b0, 10'd1, 3, 8'h01);
    step();
    chk("c1_pop", 300'({last_rd_en, last_rd_mode}), 300'(2'b10));
    step();
    chk("c1_done", 300'(exp_q.size()), 300'(0));

    // case 2 + halt on beat 2
    push_tlp(3'b011, 1'b0, 10'd8, 12, 8'h02);
    step();
    chk("c2_pop1", 300'({last_rd_en, last_rd_mode}), 300'(2'b11));
    step();
    chk("c2_pop2", 300'({last_rd_en, last_rd_mode}), 300'(2'b10));
    halt = 1'b1;
    repeat (3) step();
    halt = 1'b0;
    chk("c2_beat2_held", 300'(exp_q.size()), 300'(1));
    step();
    chk("c2_done", 300'(exp_q.size()), 300'(0));

    // case 3: maximum-length 3DW MWr
    beats_seen = 0;
    push_tlp(3'b010, 1'b0, 10'd0, 1027, 8'h03);
    drain(400, "c3");
    chk("c3_beats", 300'(beats_seen), 300'(129));
    chk("c3_last_vdw", 300'(last_vdw), 300'(3));

    // vector table, back-to-back with random halts
    foreach (tbl[i]) push_tlp(tbl[i].fmt, tbl[i].td, tbl[i].len, tbl[i].tot_dw, 8'(8'h40 + i));
    seen = 0; bubbles = 0; c = 0;
    while (exp_q.size() > 0 && c < 300) begin
      halt = ($urandom_range(0, 3) == 0);
      step();
      c++;
      if (last_valid) seen = 1;
      else if (seen != 0 && exp_q.size() > 0) bubbles++;
    end
    halt = 1'b0;
    chk("tbl_drained", 300'(exp_q.size()), 300'(0));
    chk("tbl_no_bubble", 300'(bubbles), 300'(0));

    // throttle in IDLE blocks the start
    throttle = 1'b1;
    push_tlp(3'b001, 1'b0, 10'd1, 4, 8'h10);
    repeat (3) begin
      step();
      chk("thr_idle_rd_en", 300'(last_rd_en), 300'(0));
      chk("thr_idle_valid", 300'(last_valid), 300'(0));
    end
    throttle = 1'b0;
    drain(10, "thr_idle");

    // throttle mid-TLP is ignored
    push_tlp(3'b011, 1'b1, 10'd16, 21, 8'h11);
    step();
    chk("thr_act_start", 300'(last_rd_en), 300'(1));
    throttle = 1'b1;
    drain(20, "thr_active");
    throttle = 1'b0;

    // cut-through with entries still arriving
    arrived = 2;
    push_tlp(3'b011, 1'b1, 10'd16, 21, 8'h12);
    step();
    chk("part_start", 300'({last_rd_en, last_rd_mode}), 300'(2'b11));
    step();
    chk("part_wait", 300'(last_rd_en), 300'(0));
    step();
    chk("part_bubble", 300'(last_valid), 300'(0));
    arrived = 1;
    drive_fifo();
    step();
    chk("part_need2", 300'(last_rd_en), 300'(0));
    arrived = 1 << 20;
    drive_fifo();
    drain(20, "part");

    // store-and-forward instance
    sf_rd1 = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, {3'b011, 13'h0, 1'b0, 5'h0, 10'd8}};
    sf_rd2 = {32'h7777_7777, 32'h6666_6666, 32'h5555_5555, 32'h4444_4444};
    sf_count = 10'd2;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("sf_partial_rd_en", 300'(sf_rd_en), 300'(0));
      @(posedge clk);
      #1;
      chk("sf_partial_valid", 300'(sf_valid), 300'(0));
    end
    sf_count = 10'd3;
    #1;
    chk("sf_full_pop", 300'({sf_rd_en, sf_rd_mode}), 300'(2'b11));
    @(posedge clk);
    #1;
    chk("sf_sop", 300'({sf_valid, sf_sop, sf_eop, sf_vdw, sf_length}),
        300'({1'b1, 1'b1, 1'b0, 4'd8, 11'd12}));
    chk("sf_data", 300'(sf_tlp), 300'({sf_rd2, sf_rd1}));
    sf_rd1 = {32'hBBBB_BBBB, 32'hAAAA_AAAA, 32'h9999_9999, 32'h8888_8888};
    sf_count = 10'd1;
    @(posedge clk);
    #1;
    chk("sf_eop", 300'({sf_valid, sf_sop, sf_eop, sf_vdw, sf_tlp}),
        300'({1'b1, 1'b0, 1'b1, 4'd4, 128'h0, sf_rd1}));
    sf_count = 10'd0;

    // reset in the middle of a long TLP
    push_tlp(3'b010, 1'b0, 10'd0, 1027, 8'h20);
    repeat (10) step();
    rst = 1'b1;
    step();
    chk("rst_rd_en", 300'(last_rd_en), 300'(0));
    chk("rst_outputs", 300'({tlp_valid, sop, eop, vdw, length, tlp}), 300'(0));
    fifo_q.delete();
    exp_q.delete();
    drive_fifo();
    prev_hb = 1'b0;
    rst = 1'b0;
    push_tlp(3'b000, 1'b1, 10'd0, 4, 8'h21);
    step();
    chk("post_rst_pop", 300'({last_rd_en, last_rd_mode}), 300'(2'b10));
    step();
    chk("post_rst_done", 300'(exp_q.size()), 300'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
